pll_rst_seq_ctrl: RTL and testbench

//  Bring-up and supervision controller for the 4-output PLL (50 MHz ref, clkout0..3).
//  - Runs on the free-running reference clock and drives the PLL RST pin.
//  - Qualifies LOCK, with a timeout and a bounded number of retries.
//  - Releases the per-domain resets for clkout0..3 consumers in order, once LOCK is stable.
//  - On lock loss it re-asserts all domain resets and re-runs the PLL reset sequence.

---
 rtl/pll_rst_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_pll_rst_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq_ctrl.sv
`timescale 1ns/1ps
// pll_rst_seq_ctrl
//   Bring-up and supervision controller for a 4-output PLL. Runs on the
//   free-running reference clock. It pulses the PLL reset, qualifies LOCK
//   with a timeout and a bounded retry budget, then releases the per-domain
//   resets one at a time in ascending order. If lock is lost, every domain
//   reset is re-asserted and the whole sequence starts again.
//
// Ports
//   clk           reference clock (same net as PLL clkin1)
//   rst           synchronous active-high reset
//   pll_lock_i    PLL LOCK, asynchronous (2-flop synchronized here)
//   soft_rst_req  single-cycle request to restart from the reset condition
//   pll_rst_o     PLL RST pin, active-high
//   dom_rst_o     per-domain resets, active-high, bit k serves clkout k
//   ready_o       all domains released and lock good
//   fail_o        lock not achieved within MAX_RETRY attempts (sticky)
//   retry_cnt_o   failed lock attempts in the current sequence
//   state_o       encoded FSM state for debug
module pll_rst_seq_ctrl #(
  parameter int PLL_RST_CYC  = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int REL_GAP      = 16,
  parameter int MAX_RETRY    = 3,
  parameter int N_DOM        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock_i,
  input  logic             soft_rst_req,
  output logic             pll_rst_o,
  output logic [N_DOM-1:0] dom_rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [3:0]       retry_cnt_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // One phase counter is shared by RST_PLL, STABLE and RELEASE, because only
  // one of them is active at a time. Size it for the largest of the three.
  localparam int PH_MAX = (PLL_RST_CYC > LOCK_STABLE) ?
                          ((PLL_RST_CYC > REL_GAP) ? PLL_RST_CYC : REL_GAP) :
                          ((LOCK_STABLE > REL_GAP) ? LOCK_STABLE : REL_GAP);
  localparam int PH_W  = $clog2(PH_MAX + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SYNC_STAGES = 2;

  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(PLL_RST_CYC - 1);
  localparam logic [PH_W-1:0]  STB_LAST  = PH_W'(LOCK_STABLE - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(REL_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  state_t             state_reg;
  logic [PH_W-1:0]    phase_cnt_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [3:0]         retry_cnt_reg;
  logic               pll_rst_reg;
  logic [N_DOM-1:0]   dom_rst_reg;
  logic               ready_reg;
  logic               fail_reg;
  logic [SYNC_STAGES-1:0] lock_sync_reg;

  // LOCK synchronizer. The FSM sees a LOCK edge SYNC_STAGES cycles late.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_lock_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          lock_sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          lock_sync_reg[gi] <= pll_lock_i;
        end else begin
          lock_sync_reg[gi] <= lock_sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  logic             lock_s;
  logic             tmo_hit;
  logic [TMO_W-1:0] tmo_inc;
  logic [3:0]       retry_inc;
  logic             retry_exhausted;

  assign lock_s          = lock_sync_reg[SYNC_STAGES-1];
  assign tmo_hit         = (tmo_cnt_reg >= TMO_LAST);
  // Counters saturate instead of wrapping.
  assign tmo_inc         = tmo_hit ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
  assign retry_inc       = (retry_cnt_reg == 4'hF) ? retry_cnt_reg : retry_cnt_reg + 4'd1;
  assign retry_exhausted = (retry_inc == RETRY_MAX);

  always_ff @(posedge clk) begin
    if (rst || soft_rst_req) begin
      // The soft request takes priority over everything, including a lock
      // loss or timeout in the same cycle.
      state_reg     <= ST_RST_PLL;
      phase_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      retry_cnt_reg <= '0;
      pll_rst_reg   <= 1'b1;
      dom_rst_reg   <= '1;
      ready_reg     <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_RST_PLL: begin
          pll_rst_reg <= 1'b1;
          dom_rst_reg <= '1;
          ready_reg   <= 1'b0;
          if (phase_cnt_reg >= RST_LAST) begin
            state_reg     <= ST_WAIT_LOCK;
            pll_rst_reg   <= 1'b0;
            tmo_cnt_reg   <= '0;
            phase_cnt_reg <= '0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock wins over a simultaneous timeout.
          if (lock_s) begin
            state_reg     <= ST_STABLE;
            phase_cnt_reg <= '0;
            tmo_cnt_reg   <= tmo_inc;
          end else if (tmo_hit) begin
            retry_cnt_reg <= retry_inc;
            phase_cnt_reg <= '0;
            pll_rst_reg   <= 1'b1;
            fail_reg      <= retry_exhausted;
            state_reg     <= retry_exhausted ? ST_FAIL : ST_RST_PLL;
          end else begin
            tmo_cnt_reg <= tmo_inc;
          end
        end

        ST_STABLE: begin
          // The timeout keeps running here and is not cleared on a drop back
          // to WAIT_LOCK, so a chattering lock still ends in a retry.
          if (lock_s && (phase_cnt_reg >= STB_LAST)) begin
            state_reg     <= ST_RELEASE;
            phase_cnt_reg <= '0;
            dom_rst_reg   <= dom_rst_reg << 1;
          end else if (tmo_hit) begin
            retry_cnt_reg <= retry_inc;
            phase_cnt_reg <= '0;
            pll_rst_reg   <= 1'b1;
            fail_reg      <= retry_exhausted;
            state_reg     <= retry_exhausted ? ST_FAIL : ST_RST_PLL;
          end else if (!lock_s) begin
            state_reg   <= ST_WAIT_LOCK;
            tmo_cnt_reg <= tmo_inc;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
            tmo_cnt_reg   <= tmo_inc;
          end
        end

        ST_RELEASE: begin
          if (!lock_s) begin
            state_reg     <= ST_RST_PLL;
            phase_cnt_reg <= '0;
            pll_rst_reg   <= 1'b1;
            dom_rst_reg   <= '1;
            ready_reg     <= 1'b0;
          end else if (phase_cnt_reg >= GAP_LAST) begin
            phase_cnt_reg <= '0;
            // Shifting zeros in from bit 0 keeps the release strictly in
            // ascending order; the top bit clear means every domain is out.
            if (!dom_rst_reg[N_DOM-1]) begin
              state_reg     <= ST_RUN;
              ready_reg     <= 1'b1;
              retry_cnt_reg <= '0;
            end else begin
              dom_rst_reg <= dom_rst_reg << 1;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        ST_RUN: begin
          // Lock loss is not a retry: restart the PLL reset without counting.
          if (!lock_s) begin
            state_reg     <= ST_RST_PLL;
            phase_cnt_reg <= '0;
            pll_rst_reg   <= 1'b1;
            dom_rst_reg   <= '1;
            ready_reg     <= 1'b0;
          end
        end

        ST_FAIL: begin
          pll_rst_reg <= 1'b1;
          dom_rst_reg <= '1;
          ready_reg   <= 1'b0;
          fail_reg    <= 1'b1;
        end

        default: begin
          state_reg     <= ST_RST_PLL;
          phase_cnt_reg <= '0;
          pll_rst_reg   <= 1'b1;
          dom_rst_reg   <= '1;
          ready_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o   = pll_rst_reg;
  assign dom_rst_o   = dom_rst_reg;
  assign ready_o     = ready_reg;
  assign fail_o      = fail_reg;
  assign retry_cnt_o = retry_cnt_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_pll_rst_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pll_rst_seq_ctrl with short timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pll_rst_seq_ctrl;

  localparam int N_DOM = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_lock_i = 1'b0;
  logic             soft_rst_req = 1'b0;
  logic             pll_rst_o;
  logic [N_DOM-1:0] dom_rst_o;
  logic             ready_o;
  logic             fail_o;
  logic [3:0]       retry_cnt_o;
  logic [2:0]       state_o;

  int vectors     = 0;
  int miscompares = 0;
  bit inv_en      = 1'b0;

  always #5 clk = ~clk;

  pll_rst_seq_ctrl #(
    .PLL_RST_CYC  (8),
    .LOCK_TIMEOUT (200),
    .LOCK_STABLE  (32),
    .REL_GAP      (4),
    .MAX_RETRY    (3),
    .N_DOM        (N_DOM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock_i   (pll_lock_i),
    .soft_rst_req (soft_rst_req),
    .pll_rst_o    (pll_rst_o),
    .dom_rst_o    (dom_rst_o),
    .ready_o      (ready_o),
    .fail_o       (fail_o),
    .retry_cnt_o  (retry_cnt_o),
    .state_o      (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic pll, input logic [3:0] dom,
                          input logic rdy, input logic fl, input logic [3:0] rc,
                          input logic [2:0] st);
    chk({tag, ".pll_rst"}, 32'(pll_rst_o), 32'(pll));
    chk({tag, ".dom_rst"}, 32'(dom_rst_o), 32'(dom));
    chk({tag, ".ready"},   32'(ready_o),   32'(rdy));
    chk({tag, ".fail"},    32'(fail_o),    32'(fl));
    chk({tag, ".retry"},   32'(retry_cnt_o), 32'(rc));
    chk({tag, ".state"},   32'(state_o),   32'(st));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk_outs({tag, ".rst"}, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  // Starts at the cycle the block is in RST_PLL with a cleared counter and
  // lock low; ends in RUN with lock high.
  task automatic bringup(input string tag);
    cyc(7);  chk_outs({tag, ".pll_hi"}, 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 3'd0);
    cyc(1);  chk_outs({tag, ".pll_lo"}, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 3'd1);
    cyc(50);
    pll_lock_i = 1'b1;
    cyc(34); chk_outs({tag, ".stable"}, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 3'd2);
    cyc(1);  chk_outs({tag, ".rel0"},   1'b0, 4'hE, 1'b0, 1'b0, 4'd0, 3'd3);
    cyc(3);  chk({tag, ".rel0_hold"}, 32'(dom_rst_o), 32'hE);
    cyc(1);  chk({tag, ".rel1"},      32'(dom_rst_o), 32'hC);
    cyc(4);  chk({tag, ".rel2"},      32'(dom_rst_o), 32'h8);
    cyc(4);  chk_outs({tag, ".rel3"},   1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 3'd3);
    cyc(4);  chk_outs({tag, ".run"},    1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 3'd4);
    $display("%s: bring-up sequence done", tag);
  endtask

  // Ordering and PLL-reset invariants, checked on every cycle after reset.
  always @(negedge clk) begin
    logic [3:0] nd;
    logic       ok;
    if (inv_en) begin
      nd = ~dom_rst_o;
      ok = ((nd & (nd + 4'd1)) == 4'd0) && (!pll_rst_o || dom_rst_o == 4'hF);
      chk("invariant", 32'(ok), 32'd1);
    end
  end

  initial begin
    // Test 1: plain bring-up after rst.
    do_reset("t1");
    inv_en = 1'b1;
    bringup("t1");

    // Test 4: one-cycle lock drop in RUN, full rerun without a retry.
    pll_lock_i = 1'b0;
    cyc(1);
    pll_lock_i = 1'b1;
    cyc(1);  chk_outs("t4.pre",  1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 3'd4);
    cyc(1);  chk_outs("t4.lost", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 3'd0);
    cyc(8);  chk_outs("t4.pll_lo", 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 3'd1);
    cyc(32); chk_outs("t4.stable", 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 3'd2);
    cyc(1);  chk_outs("t4.rel0",   1'b0, 4'hE, 1'b0, 1'b0, 4'd0, 3'd3);
    cyc(16); chk_outs("t4.run",    1'b0, 4'h0, 1'b1, 1'b0, 4'd0, 3'd4);
    $display("t4: lock-loss recovery done");

    // Test 2: lock never comes; three timeouts then FAIL latched.
    pll_lock_i = 1'b0;
    do_reset("t2");
    for (int a = 1; a <= 3; a++) begin
      cyc(7);   chk("t2.pll_hi", 32'(pll_rst_o), 32'd1);
      cyc(1);   chk("t2.pll_lo", 32'(pll_rst_o), 32'd0);
                chk("t2.wait_st", 32'(state_o), 32'd1);
      cyc(199); chk("t2.pre_tmo_retry", 32'(retry_cnt_o), 32'(a - 1));
                chk("t2.pre_tmo_st", 32'(state_o), 32'd1);
      cyc(1);   chk("t2.retry", 32'(retry_cnt_o), 32'(a));
                chk("t2.pll_re", 32'(pll_rst_o), 32'd1);
                chk("t2.state", 32'(state_o), (a == 3) ? 32'd5 : 32'd0);
                chk("t2.fail", 32'(fail_o), (a == 3) ? 32'd1 : 32'd0);
      $display("t2: attempt %0d timed out, retry_cnt=%0d", a, retry_cnt_o);
    end
    cyc(1000);
    chk_outs("t2.held", 1'b1, 4'hF, 1'b0, 1'b1, 4'd3, 3'd5);

    // Test 5: soft reset out of FAIL, then normal bring-up.
    soft_rst_req = 1'b1;
    cyc(1);
    soft_rst_req = 1'b0;
    chk_outs("t5.soft", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 3'd0);
    bringup("t5");

    // Test 3: chattering lock (20 high / 5 low) never qualifies and times out.
    pll_lock_i = 1'b0;
    do_reset("t3");
    cyc(8);
    chk("t3.pll_lo", 32'(pll_rst_o), 32'd0);
    pll_lock_i = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      chk("t3.dom", 32'(dom_rst_o), 32'hF);
      chk("t3.retry", 32'(retry_cnt_o), (i == 200) ? 32'd1 : 32'd0);
      pll_lock_i = ((i % 25) < 20);
    end
    chk("t3.state", 32'(state_o), 32'd0);
    chk("t3.pll_re", 32'(pll_rst_o), 32'd1);
    $display("t3: chattering lock timed out");

    // Test 6: rst in the middle of RELEASE.
    pll_lock_i = 1'b0;
    do_reset("t6");
    cyc(8);
    cyc(50);
    pll_lock_i = 1'b1;
    cyc(35); chk("t6.rel0", 32'(dom_rst_o), 32'hE);
    cyc(4);  chk("t6.rel1", 32'(dom_rst_o), 32'hC);
    rst = 1'b1;
    cyc(1);  chk_outs("t6.rst", 1'b1, 4'hF, 1'b0, 1'b0, 4'd0, 3'd0);
    rst = 1'b0;
    cyc(1);  chk("t6.after", 32'(dom_rst_o), 32'hF);
    $display("t6: mid-release reset done");

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
